// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if: fetch-side and decode-side handshake bundle of the immediate-generation stage.
interface imm_gen_stage_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_imm_type;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;
    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_target, out_illegal
    );
    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type, out_target, out_illegal
    );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RV32/RV64 immediate generator with PC-relative target and optional skid buffer.
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input logic clk,
    input logic rst,
    imm_gen_stage_if.slave bus
);
    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_SH   = 3'd6;
    localparam bit         RV64   = (XLEN == 64);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    entry_t          dec, out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [31:0]     i;
    logic [6:0]      op;
    logic            op_imm, op_imm32, shamt, rel, ill;
    logic [2:0]      typ;
    logic [31:0]     imm32;
    logic [XLEN-1:0] shamt_imm;
    logic            in_ready, in_fire, out_adv;

    assign i         = bus.in_instr;
    assign op        = i[6:0];
    assign op_imm    = op == 7'b0010011;
    assign op_imm32  = RV64 && op == 7'b0011011;
    assign shamt     = (op_imm || op_imm32) && i[13:12] == 2'b01;
    assign shamt_imm = (RV64 && op_imm) ? XLEN'(i[25:20]) : XLEN'(i[24:20]);
    assign rel       = typ == T_B || typ == T_J || op == 7'b0010111;

    // Immediates are assembled as 32-bit signed values and widened once, so RV64 sign-fills bits 63:32.
    always_comb begin
        typ   = T_NONE;
        ill   = 1'b0;
        imm32 = '0;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                typ   = T_I;
                imm32 = {{20{i[31]}}, i[31:20]};
            end
            7'b0011011: begin
                typ   = RV64 ? T_I : T_NONE;
                imm32 = RV64 ? {{20{i[31]}}, i[31:20]} : '0;
                ill   = !RV64;
            end
            7'b0100011: begin
                typ   = T_S;
                imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
            end
            7'b1100011: begin
                typ   = T_B;
                imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                typ   = T_U;
                imm32 = {i[31:12], 12'h000};
            end
            7'b1101111: begin
                typ   = T_J;
                imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b0110011, 7'b1110011: begin
            end
            7'b0111011: ill = !RV64;
            default:    ill = 1'b1;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.instr   = i;
        dec.pc      = bus.in_pc;
        dec.typ     = shamt ? T_SH : typ;
        dec.illegal = ill;
        dec.imm     = shamt ? shamt_imm : XLEN'($signed(imm32));
        dec.target  = rel ? bus.in_pc + dec.imm : '0;
    end

    assign in_ready = SKID ? !skid_valid_q : (!out_valid_q || bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_adv  = !out_valid_q || bus.out_ready;

    // The skid slot only fills while the output is stalled, so the in_ready register gating is enough to keep order.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_adv) begin
            out_valid_d  = skid_valid_q || in_fire;
            out_d        = skid_valid_q ? skid_q : in_fire ? dec : out_q;
            skid_valid_d = 1'b0;
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_instr    = out_q.instr;
    assign bus.out_pc       = out_q.pc;
    assign bus.out_imm      = out_q.imm;
    assign bus.out_imm_type = out_q.typ;
    assign bus.out_target   = out_q.target;
    assign bus.out_illegal  = out_q.illegal;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: scoreboard bench for an RV32 skid-buffered stage and an RV64 single-register stage.
module tb_imm_gen_stage;
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    exp_t q32[$];
    exp_t q64[$];

    imm_gen_stage_if #(.XLEN(32)) b32 ();
    imm_gen_stage_if #(.XLEN(64)) b64 ();

    imm_gen_stage #(.XLEN(32), .SKID(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_stage #(.XLEN(64), .SKID(1'b0)) dut64 (.clk(clk), .rst(rst), .bus(b64));

    always #5 clk = ~clk;

    task automatic drive_idle();
        b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
        b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b1;
    endtask

    function automatic exp_t make_item();
        exp_t        e;
        logic [11:0] i12;
        logic [19:0] u20;
        i12   = 12'($urandom);
        u20   = 20'($urandom);
        e.pc  = {$urandom, $urandom};
        e.tgt = '0;
        e.ill = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
            e.instr = {i12, 5'd2, 3'b000, 5'd1, 7'b0010011};
            e.imm   = {{52{i12[11]}}, i12};
            e.typ   = 3'd1;
        end else begin
            e.instr = {u20, 5'd3, 7'b0110111};
            e.imm   = {{32{u20[19]}}, u20, 12'h000};
            e.typ   = 3'd4;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        b32.in_valid = 1'b1; b32.in_instr = 32'hFFF00093;
        b64.in_valid = 1'b1; b64.in_instr = 32'h800000B7;
        repeat (3) @(negedge clk);
        checks++;
        if ({b32.out_valid, b32.out_instr, b32.out_pc, b32.out_imm, b32.out_imm_type, b32.out_target, b32.out_illegal} !== '0)
            $display("FAIL reset32 outputs got v=%b instr=%h imm=%h want all zero", b32.out_valid, b32.out_instr, b32.out_imm);
        else passes++;
        checks++;
        if ({b64.out_valid, b64.out_instr, b64.out_pc, b64.out_imm, b64.out_imm_type, b64.out_target, b64.out_illegal} !== '0)
            $display("FAIL reset64 outputs got v=%b instr=%h imm=%h want all zero", b64.out_valid, b64.out_instr, b64.out_imm);
        else passes++;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({b32.in_ready, b32.out_valid} !== 2'b10) $display("FAIL post_reset32 got ready=%b valid=%b want ready=1 valid=0", b32.in_ready, b32.out_valid);
        else passes++;
        checks++;
        if ({b64.in_ready, b64.out_valid} !== 2'b10) $display("FAIL post_reset64 got ready=%b valid=%b want ready=1 valid=0", b64.in_ready, b64.out_valid);
        else passes++;
    endtask

    task automatic test_decode32();
        exp_t t[13];
        exp_t e;
        t[0]  = '{32'hFFF00093, 64'h0,        64'hFFFFFFFF, 64'h0,    3'd1, 1'b0};
        t[1]  = '{32'h4030D093, 64'h4,        64'h3,        64'h0,    3'd6, 1'b0};
        t[2]  = '{32'hFFE11083, 64'h8,        64'hFFFFFFFE, 64'h0,    3'd1, 1'b0};
        t[3]  = '{32'hFE000EE3, 64'h100,      64'hFFFFFFFC, 64'hFC,   3'd3, 1'b0};
        t[4]  = '{32'h0080006F, 64'hFFFFFFFC, 64'h8,        64'h4,    3'd5, 1'b0};
        t[5]  = '{32'hFE112E23, 64'h10,       64'hFFFFFFFC, 64'h0,    3'd2, 1'b0};
        t[6]  = '{32'h00001097, 64'h200,      64'h1000,     64'h1200, 3'd4, 1'b0};
        t[7]  = '{32'h0000001B, 64'h14,       64'h0,        64'h0,    3'd0, 1'b1};
        t[8]  = '{32'h003100B3, 64'h18,       64'h0,        64'h0,    3'd0, 1'b0};
        t[9]  = '{32'hFFC08067, 64'h300,      64'hFFFFFFFC, 64'h0,    3'd1, 1'b0};
        t[10] = '{32'h00000001, 64'h1C,       64'h0,        64'h0,    3'd0, 1'b1};
        t[11] = '{32'h0FF0000F, 64'h20,       64'hFF,       64'h0,    3'd1, 1'b0};
        t[12] = '{32'h00000073, 64'h24,       64'h0,        64'h0,    3'd0, 1'b0};
        foreach (t[k]) begin
            b32.in_valid = 1'b1; b32.in_instr = t[k].instr; b32.in_pc = t[k].pc[31:0];
            q32.push_back(t[k]);
            @(negedge clk);
            b32.in_valid = 1'b0;
            e = q32.pop_front();
            checks++;
            if ({b32.out_valid, b32.out_instr, b32.out_pc, b32.out_imm, b32.out_imm_type, b32.out_target, b32.out_illegal} !==
                {1'b1, e.instr, e.pc[31:0], e.imm[31:0], e.typ, e.tgt[31:0], e.ill})
                $display("FAIL decode32[%0d] got v=%b instr=%h pc=%h imm=%h type=%0d tgt=%h ill=%b want instr=%h pc=%h imm=%h type=%0d tgt=%h ill=%b",
                         k, b32.out_valid, b32.out_instr, b32.out_pc, b32.out_imm, b32.out_imm_type, b32.out_target, b32.out_illegal,
                         e.instr, e.pc[31:0], e.imm[31:0], e.typ, e.tgt[31:0], e.ill);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_decode64();
        exp_t t[10];
        exp_t e;
        t[0] = '{32'h800000B7, 64'h0,                  64'hFFFFFFFF80000000, 64'h0,                  3'd4, 1'b0};
        t[1] = '{32'h4210D093, 64'h4,                  64'd33,               64'h0,                  3'd6, 1'b0};
        t[2] = '{32'h0000007F, 64'h8,                  64'h0,                64'h0,                  3'd0, 1'b1};
        t[3] = '{32'hFFF0809B, 64'hC,                  64'hFFFFFFFFFFFFFFFF, 64'h0,                  3'd1, 1'b0};
        t[4] = '{32'h0050909B, 64'h10,                 64'd5,                64'h0,                  3'd6, 1'b0};
        t[5] = '{32'h003100BB, 64'h14,                 64'h0,                64'h0,                  3'd0, 1'b0};
        t[6] = '{32'hFE000EE3, 64'h0,                  64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC,   3'd3, 1'b0};
        t[7] = '{32'h0080006F, 64'hFFFFFFFFFFFFFFFC,   64'h8,                64'h4,                  3'd5, 1'b0};
        t[8] = '{32'h00001097, 64'h8000000000000000,   64'h1000,             64'h8000000000001000,   3'd4, 1'b0};
        t[9] = '{32'h03F09093, 64'h18,                 64'd63,               64'h0,                  3'd6, 1'b0};
        foreach (t[k]) begin
            b64.in_valid = 1'b1; b64.in_instr = t[k].instr; b64.in_pc = t[k].pc;
            q64.push_back(t[k]);
            @(negedge clk);
            b64.in_valid = 1'b0;
            e = q64.pop_front();
            checks++;
            if ({b64.out_valid, b64.out_instr, b64.out_pc, b64.out_imm, b64.out_imm_type, b64.out_target, b64.out_illegal} !==
                {1'b1, e.instr, e.pc, e.imm, e.typ, e.tgt, e.ill})
                $display("FAIL decode64[%0d] got v=%b instr=%h pc=%h imm=%h type=%0d tgt=%h ill=%b want instr=%h pc=%h imm=%h type=%0d tgt=%h ill=%b",
                         k, b64.out_valid, b64.out_instr, b64.out_pc, b64.out_imm, b64.out_imm_type, b64.out_target, b64.out_illegal,
                         e.instr, e.pc, e.imm, e.typ, e.tgt, e.ill);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_skid0_ready();
        b64.out_ready = 1'b0;
        b64.in_valid = 1'b1; b64.in_instr = 32'hFFF00093; b64.in_pc = 64'h40;
        @(negedge clk);
        b64.in_instr = 32'h00500093; b64.in_pc = 64'h44;
        #1;
        checks++;
        if (b64.in_ready !== 1'b0) $display("FAIL skid0_stall_ready got %b want 0", b64.in_ready);
        else passes++;
        @(negedge clk);
        checks++;
        if ({b64.out_valid, b64.out_instr, b64.out_imm} !== {1'b1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF})
            $display("FAIL skid0_hold got v=%b instr=%h imm=%h want v=1 instr=fff00093 imm=ffffffffffffffff", b64.out_valid, b64.out_instr, b64.out_imm);
        else passes++;
        b64.out_ready = 1'b1;
        #1;
        checks++;
        if (b64.in_ready !== 1'b1) $display("FAIL skid0_release_ready got %b want 1", b64.in_ready);
        else passes++;
        @(negedge clk);
        b64.in_valid = 1'b0;
        checks++;
        if ({b64.out_valid, b64.out_instr, b64.out_pc, b64.out_imm} !== {1'b1, 32'h00500093, 64'h44, 64'd5})
            $display("FAIL skid0_replace got v=%b instr=%h pc=%h imm=%h want v=1 instr=00500093 pc=44 imm=5", b64.out_valid, b64.out_instr, b64.out_pc, b64.out_imm);
        else passes++;
        @(negedge clk);
        checks++;
        if (b64.out_valid !== 1'b0) $display("FAIL skid0_drain got valid=%b want 0", b64.out_valid);
        else passes++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic in_fire;
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_instr = 32'h00100093; b32.in_pc = 32'h10;
        q32.push_back('{32'h00100093, 64'h10, 64'd1, 64'h0, 3'd1, 1'b0});
        @(negedge clk);
        checks++;
        if ({b32.out_valid, b32.out_instr, b32.in_ready} !== {1'b1, 32'h00100093, 1'b1})
            $display("FAIL bp_a got v=%b instr=%h ready=%b want v=1 instr=00100093 ready=1", b32.out_valid, b32.out_instr, b32.in_ready);
        else passes++;
        b32.in_instr = 32'h00200113; b32.in_pc = 32'h14;
        q32.push_back('{32'h00200113, 64'h14, 64'd2, 64'h0, 3'd1, 1'b0});
        @(negedge clk);
        b32.in_instr = 32'h00300193; b32.in_pc = 32'h18;
        checks++;
        if ({b32.out_instr, b32.in_ready} !== {32'h00100093, 1'b0})
            $display("FAIL bp_skid_full got instr=%h ready=%b want instr=00100093 ready=0", b32.out_instr, b32.in_ready);
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if ({b32.out_valid, b32.out_instr, b32.in_ready} !== {1'b1, 32'h00100093, 1'b0})
            $display("FAIL bp_hold got v=%b instr=%h ready=%b want v=1 instr=00100093 ready=0", b32.out_valid, b32.out_instr, b32.in_ready);
        else passes++;
        q32.push_back('{32'h00300193, 64'h18, 64'd3, 64'h0, 3'd1, 1'b0});
        b32.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && q32.size() > 0; cyc++) begin
            in_fire = b32.in_valid && b32.in_ready;
            if (b32.out_valid) begin
                e = q32.pop_front();
                checks++;
                if ({b32.out_instr, b32.out_pc, b32.out_imm} !== {e.instr, e.pc[31:0], e.imm[31:0]})
                    $display("FAIL bp_order got instr=%h pc=%h imm=%h want instr=%h pc=%h imm=%h", b32.out_instr, b32.out_pc, b32.out_imm, e.instr, e.pc[31:0], e.imm[31:0]);
                else passes++;
            end
            @(negedge clk);
            if (in_fire) b32.in_valid = 1'b0;
        end
        checks++;
        if (q32.size() != 0) begin
            $display("FAIL bp_drain_timeout got %0d entries left want 0", q32.size());
            q32.delete();
        end else passes++;
        checks++;
        if (b32.out_valid !== 1'b0) $display("FAIL bp_no_dup got valid=%b want 0", b32.out_valid);
        else passes++;
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t cur, e;
        int   got, sent;
        logic in_fire, out_fire;
        got = 0; sent = 0; cur = make_item();
        b32.in_valid = 1'b1; b32.in_instr = cur.instr; b32.in_pc = cur.pc[31:0];
        for (int cyc = 0; cyc < 1000 && got < 40; cyc++) begin
            b32.out_ready = $urandom_range(0, 3) != 0;
            #1;
            in_fire  = b32.in_valid && b32.in_ready;
            out_fire = b32.out_valid && b32.out_ready;
            if (out_fire) begin
                got++;
                checks++;
                if (q32.size() == 0) $display("FAIL b2b32_extra got instr=%h want no output", b32.out_instr);
                else begin
                    e = q32.pop_front();
                    if ({b32.out_instr, b32.out_pc, b32.out_imm, b32.out_imm_type} !== {e.instr, e.pc[31:0], e.imm[31:0], e.typ})
                        $display("FAIL b2b32 got instr=%h pc=%h imm=%h type=%0d want instr=%h pc=%h imm=%h type=%0d",
                                 b32.out_instr, b32.out_pc, b32.out_imm, b32.out_imm_type, e.instr, e.pc[31:0], e.imm[31:0], e.typ);
                    else passes++;
                end
            end
            if (in_fire) begin q32.push_back(cur); sent++; end
            @(negedge clk);
            if (in_fire || !b32.in_valid) begin
                cur = make_item();
                b32.in_valid = sent < 40 && $urandom_range(0, 2) != 0;
                b32.in_instr = cur.instr; b32.in_pc = cur.pc[31:0];
            end
        end
        checks++;
        if (got != 40) $display("FAIL b2b32_count got %0d want 40", got);
        else passes++;
        got = 0; sent = 0; cur = make_item();
        b64.in_valid = 1'b1; b64.in_instr = cur.instr; b64.in_pc = cur.pc;
        for (int cyc = 0; cyc < 1000 && got < 40; cyc++) begin
            b64.out_ready = $urandom_range(0, 3) != 0;
            #1;
            in_fire  = b64.in_valid && b64.in_ready;
            out_fire = b64.out_valid && b64.out_ready;
            if (out_fire) begin
                got++;
                checks++;
                if (q64.size() == 0) $display("FAIL b2b64_extra got instr=%h want no output", b64.out_instr);
                else begin
                    e = q64.pop_front();
                    if ({b64.out_instr, b64.out_pc, b64.out_imm, b64.out_imm_type} !== {e.instr, e.pc, e.imm, e.typ})
                        $display("FAIL b2b64 got instr=%h pc=%h imm=%h type=%0d want instr=%h pc=%h imm=%h type=%0d",
                                 b64.out_instr, b64.out_pc, b64.out_imm, b64.out_imm_type, e.instr, e.pc, e.imm, e.typ);
                    else passes++;
                end
            end
            if (in_fire) begin q64.push_back(cur); sent++; end
            @(negedge clk);
            if (in_fire || !b64.in_valid) begin
                cur = make_item();
                b64.in_valid = sent < 40 && $urandom_range(0, 2) != 0;
                b64.in_instr = cur.instr; b64.in_pc = cur.pc;
            end
        end
        checks++;
        if (got != 40) $display("FAIL b2b64_count got %0d want 40", got);
        else passes++;
        drive_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_instr = 32'h00100093; b32.in_pc = 32'h10;
        @(negedge clk);
        b32.in_instr = 32'h00200113;
        @(negedge clk);
        checks++;
        if ({b32.out_valid, b32.in_ready} !== 2'b10) $display("FAIL flush_setup got v=%b ready=%b want v=1 ready=0", b32.out_valid, b32.in_ready);
        else passes++;
        b32.in_instr = 32'h00300193; b32.flush = 1'b1;
        b64.in_valid = 1'b1; b64.in_instr = 32'h00700093; b64.flush = 1'b1;
        @(negedge clk);
        b32.flush = 1'b0; b64.flush = 1'b0;
        checks++;
        if ({b32.out_valid, b32.in_ready} !== 2'b01) $display("FAIL flush32 got v=%b ready=%b want v=0 ready=1", b32.out_valid, b32.in_ready);
        else passes++;
        checks++;
        if (b64.out_valid !== 1'b0) $display("FAIL flush64_drop got v=%b want 0", b64.out_valid);
        else passes++;
        b32.in_valid = 1'b0; b64.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({b32.out_valid, b64.out_valid} !== 2'b00) $display("FAIL flush_after got v32=%b v64=%b want 0 0", b32.out_valid, b64.out_valid);
        else passes++;
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.in_instr = 32'hFE000EE3; b32.in_pc = 32'h100;
        @(negedge clk);
        b32.in_instr = 32'h0080006F;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({b32.out_valid, b32.out_instr, b32.out_pc, b32.out_imm, b32.out_imm_type, b32.out_target, b32.out_illegal} !== '0)
            $display("FAIL rst_mid got v=%b instr=%h imm=%h tgt=%h want all zero", b32.out_valid, b32.out_instr, b32.out_imm, b32.out_target);
        else passes++;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({b32.in_ready, b32.out_valid} !== 2'b10) $display("FAIL rst_mid_skid got ready=%b v=%b want ready=1 v=0", b32.in_ready, b32.out_valid);
        else passes++;
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_decode32();
        test_decode64();
        test_skid0_ready();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
